// File: rtl/room_move_ctrl.sv
// Move sequencer in front of roomFSM: synchronises and debounces four direction buttons,
// issues one n/s/e/w pulse per press, then samples roomFSM win/death status.
module room_move_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SETTLE_CYCLES   = 2,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_n,
   input  logic             btn_s,
   input  logic             btn_e,
   input  logic             btn_w,
   input  logic             win_in,
   input  logic             dead_in,
   output logic             n,
   output logic             s,
   output logic             e,
   output logic             w,
   output logic             busy,
   output logic             game_over,
   output logic             won,
   output logic [CNT_W-1:0] move_count
);

   localparam int CMAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      ISSUE,
      SETTLE,
      WAIT_RELEASE,
      OVER
   } state_t;

   state_t          state;
   logic [3:0]      sync1;
   logic [3:0]      sync2;
   logic [1:0]      sync_ok;
   logic [3:0]      dir;
   logic [3:0]      pick;
   logic [CW-1:0]   cnt;

   // Button vectors are ordered {n, s, e, w}, so the highest set bit wins arbitration.
   always_comb begin
      pick = 4'b0001;
      if (sync2[3])      pick = 4'b1000;
      else if (sync2[2]) pick = 4'b0100;
      else if (sync2[1]) pick = 4'b0010;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_RELEASE;
         sync1        <= '0;
         sync2        <= '0;
         sync_ok      <= '0;
         dir          <= '0;
         cnt          <= '0;
         {n, s, e, w} <= '0;
         busy         <= 1'b0;
         game_over    <= 1'b0;
         won          <= 1'b0;
         move_count   <= '0;
      end else begin
         sync1        <= {btn_n, btn_s, btn_e, btn_w};
         sync2        <= sync1;
         sync_ok      <= {sync_ok[0], 1'b1};
         {n, s, e, w} <= (state == ISSUE) ? dir : '0;
         busy         <= (state != IDLE);
         game_over    <= (state == OVER);

         case (state)
            IDLE: begin
               if (|sync2) begin
                  dir   <= pick;
                  cnt   <= '0;
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if ((sync2 & dir) == '0)
                  state <= IDLE;
               else if (cnt == CW'(DEBOUNCE_CYCLES - 1))
                  state <= ISSUE;
               else
                  cnt <= cnt + CW'(1);
            end
            ISSUE: begin
               if (move_count != '1)
                  move_count <= move_count + CNT_W'(1);
               cnt   <= '0;
               state <= SETTLE;
            end
            SETTLE: begin
               if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                  if (win_in) begin
                     won   <= 1'b1;
                     state <= OVER;
                  end else if (dead_in) begin
                     won   <= 1'b0;
                     state <= OVER;
                  end else begin
                     state <= WAIT_RELEASE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_RELEASE: begin
               // Synchroniser zeros straight out of reset are not a real release.
               if (sync_ok[1] && sync2 == '0)
                  state <= IDLE;
            end
            OVER: state <= OVER;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_room_move_ctrl.sv
// Self-checking bench for room_move_ctrl: a timeline model checked every cycle against two
// instances (8-bit and 2-bit move counters) plus directed literal expectations.
module tb_room_move_ctrl;

   localparam int DB = 4;
   localparam int ST = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
   logic       win_in = 1'b0, dead_in = 1'b0;
   logic       n, s, e, w, busy, game_over, won;
   logic [7:0] move_count;
   logic       n2, s2, e2, w2, busy2, go2, won2;
   logic [1:0] mc2;

   always #5 clk = ~clk;

   room_move_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
      .win_in(win_in), .dead_in(dead_in), .n(n), .s(s), .e(e), .w(w), .busy(busy),
      .game_over(game_over), .won(won), .move_count(move_count));

   room_move_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
      .win_in(win_in), .dead_in(dead_in), .n(n2), .s(s2), .e(e2), .w(w2), .busy(busy2),
      .game_over(go2), .won(won2), .move_count(mc2));

   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Timeline model: phases with absolute deadlines, synced view is raw input two edges back.
   typedef enum {M_IDLE, M_DEB, M_PULSE, M_SETTLE, M_HOLD, M_OVER} mph_t;
   mph_t       ph = M_HOLD;
   logic [3:0] d1 = '0, d2 = '0, mdir = '0, x_pulse = '0;
   logic       x_busy = 1'b0, x_go = 1'b0, x_won = 1'b0;
   int         deadline = 0, warm = 0, moves = 0;

   always @(posedge clk) begin
      logic [3:0] v;
      cyc++;
      if (reset) begin
         ph = M_HOLD; d1 = '0; d2 = '0; warm = 0; moves = 0;
         x_pulse = '0; x_busy = 1'b0; x_go = 1'b0; x_won = 1'b0;
      end else begin
         v       = d2;
         x_busy  = (ph != M_IDLE);
         x_go    = (ph == M_OVER);
         x_pulse = (ph == M_PULSE) ? mdir : 4'b0000;
         case (ph)
            M_IDLE: if (v != 0) begin
               mdir = v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : 4'b0001;
               deadline = cyc + DB;
               ph = M_DEB;
            end
            M_DEB: if ((v & mdir) == 0) ph = M_IDLE;
                   else if (cyc == deadline) ph = M_PULSE;
            M_PULSE: begin moves++; deadline = cyc + ST; ph = M_SETTLE; end
            M_SETTLE: if (cyc == deadline) begin
               if (win_in) begin x_won = 1'b1; ph = M_OVER; end
               else if (dead_in) begin x_won = 1'b0; ph = M_OVER; end
               else ph = M_HOLD;
            end
            M_HOLD: if (warm >= 2 && v == 0) ph = M_IDLE;
            default: ;
         endcase
         if (warm < 2) warm++;
         d2 = d1;
         d1 = {btn_n, btn_s, btn_e, btn_w};
      end
   end

   int pn = 0, ps = 0, pe = 0, pw = 0;
   int e_last = -1, busy_fall = -1;
   logic prev_busy = 1'b0;

   always @(posedge clk) begin
      #1;
      check("pulses", {n, s, e, w}, x_pulse);
      check("busy", busy, x_busy);
      check("game_over", game_over, x_go);
      if (x_go) check("won", won, x_won);
      check("move_count", move_count, (moves > 255) ? 255 : moves);
      check("pulses_w2", {n2, s2, e2, w2}, x_pulse);
      check("busy_w2", busy2, x_busy);
      check("game_over_w2", go2, x_go);
      if (x_go) check("won_w2", won2, x_won);
      check("move_count_w2", mc2, (moves > 3) ? 3 : moves);
      if (n) pn++;
      if (s) ps++;
      if (e) begin pe++; e_last = cyc; end
      if (w) pw++;
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(5);
   endtask

   task automatic press(input logic [3:0] m, input int hold, input int gap);
      {btn_n, btn_s, btn_e, btn_w} = m;
      tick(hold);
      {btn_n, btn_s, btn_e, btn_w} = 4'b0000;
      tick(gap);
   endtask

   initial begin
      int base, k, rel;
      logic seen;

      // 1: button held through reset never moves
      btn_e = 1'b1;
      tick(20);
      reset = 1'b0;
      tick(5);
      btn_e = 1'b0;
      tick(6);
      check("t1_pulses", pn + ps + pe + pw, 0);
      check("t1_count", move_count, 0);
      check("t1_busy", busy, 0);

      // 2: single east press, latency and release timing
      do_reset();
      base = pe;
      btn_e = 1'b1;
      k = cyc + 1;
      tick(10);
      btn_e = 1'b0;
      rel = cyc + 1;
      tick(8);
      check("t2_e_pulses", pe - base, 1);
      check("t2_e_cycle", e_last - k, 7);
      check("t2_count", move_count, 1);
      check("t2_busy_fall", busy_fall - rel, 3);

      // 3: glitch shorter than debounce
      do_reset();
      base = pn + ps + pe + pw;
      press(4'b0100, 3, 8);
      check("t3_pulses", pn + ps + pe + pw - base, 0);
      check("t3_count", move_count, 0);
      check("t3_busy", busy, 0);

      // 4: north and west together, north wins
      do_reset();
      base = pn;
      rel = pw;
      press(4'b1001, 10, 8);
      check("t4_n_pulses", pn - base, 1);
      check("t4_w_pulses", pw - rel, 0);

      // 6: saturation of the 2-bit counter, then reset mid-SETTLE
      do_reset();
      for (int i = 0; i < 5; i++) press(4'b0010, 8, 6);
      check("t6_count8", move_count, 5);
      check("t6_count2", mc2, 3);
      seen = 1'b0;
      btn_w = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (w) seen = 1'b1;
      end
      check("t6_w_seen", seen, 1);
      reset = 1'b1;
      tick(1);
      check("t6_rst_count", move_count, 0);
      check("t6_rst_count2", mc2, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_pulse", {n, s, e, w}, 0);
      reset = 1'b0;
      btn_w = 1'b0;
      tick(6);

      // 5: win, then death, then both
      do_reset();
      win_in = 1'b1;
      press(4'b0010, 10, 8);
      check("t5_win_over", game_over, 1);
      check("t5_win_won", won, 1);
      base = pn + ps + pe + pw;
      press(4'b1000, 10, 8);
      check("t5_no_more", pn + ps + pe + pw - base, 0);
      check("t5_still_over", game_over, 1);
      win_in = 1'b0;
      dead_in = 1'b1;
      do_reset();
      press(4'b0100, 10, 8);
      check("t5_dead_over", game_over, 1);
      check("t5_dead_won", won, 0);
      win_in = 1'b1;
      do_reset();
      press(4'b0001, 10, 8);
      check("t5_both_over", game_over, 1);
      check("t5_both_won", won, 1);
      win_in = 1'b0;
      dead_in = 1'b0;
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
